// File: rtl/cordic_prep_if.sv
// Handshake and operand bundle between the CORDIC front end and its neighbours.
//   master : angle source / back end (drives in_valid, angle_in, out_ready)
//   slave  : cordic_prep (drives in_ready, sh_en, stage-0 operands, tail tags, busy)
interface cordic_prep_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] angle_in;
  logic               out_ready;
  logic               sh_en;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic signed [15:0] z_out;
  logic               tail_valid;
  logic               tail_flip;
  logic               busy;

  modport master (
    output in_valid, angle_in, out_ready,
    input  in_ready, sh_en, x_out, y_out, z_out, tail_valid, tail_flip, busy
  );

  modport slave (
    input  in_valid, angle_in, out_ready,
    output in_ready, sh_en, x_out, y_out, z_out, tail_valid, tail_flip, busy
  );
endinterface

// File: rtl/cordic_prep.sv
// cordic_prep: front end of the CORDIC rotation pipeline.
// Accepts Q3.13 angles over valid/ready, clamps to [-pi, pi], folds into
// [-pi/2, pi/2], and loads stage-0 operands (x = K, y = 0, z = folded angle).
// A valid/flip tag delay line tracks each sample down to the last stage so
// the back end knows whether to negate cos/sin.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - cordic_prep_if.slave: in_valid/in_ready/angle_in, out_ready,
//          sh_en, x_out/y_out/z_out, tail_valid/tail_flip, busy
module cordic_prep #(
  parameter int unsigned        STAGES      = 16,
  parameter logic signed [15:0] ANG_PI      = 16'sd25736,
  parameter logic signed [15:0] ANG_HALF_PI = 16'sd12868,
  parameter logic signed [15:0] K_INIT      = 16'sd9949
) (
  input  logic          clk,
  input  logic          rst,
  cordic_prep_if.slave  bus
);

  localparam logic signed [15:0] NEG_PI      = -ANG_PI;
  localparam logic signed [15:0] NEG_HALF_PI = -ANG_HALF_PI;

  logic               sh_en;
  logic               accept;
  logic signed [15:0] clamped;
  logic signed [15:0] folded;
  logic               fold_flip;

  logic [STAGES:0]    vld;
  logic [STAGES:0]    flip;
  logic signed [15:0] x_q, y_q, z_q;

  // Whole chain moves in lockstep with the back end; reset freezes it too.
  assign sh_en  = bus.out_ready & ~rst;
  assign accept = bus.in_valid & sh_en;

  always_comb begin
    clamped   = bus.angle_in;
    folded    = '0;
    fold_flip = 1'b0;
    if (bus.angle_in > ANG_PI) begin
      clamped = ANG_PI;
    end else if (bus.angle_in < NEG_PI) begin
      clamped = NEG_PI;
    end
    // Boundary values +/-pi/2 stay unfolded.
    if (clamped > ANG_HALF_PI) begin
      folded    = clamped - ANG_PI;
      fold_flip = 1'b1;
    end else if (clamped < NEG_HALF_PI) begin
      folded    = clamped + ANG_PI;
      fold_flip = 1'b1;
    end else begin
      folded    = clamped;
      fold_flip = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      vld  <= '0;
      flip <= '0;
    end else if (sh_en) begin
      // Non-accepted cycles inject a zeroed bubble.
      x_q  <= accept ? K_INIT : '0;
      y_q  <= '0;
      z_q  <= accept ? folded : '0;
      vld  <= {vld[STAGES-1:0], accept};
      flip <= {flip[STAGES-1:0], accept & fold_flip};
    end
  end

  assign bus.sh_en      = sh_en;
  assign bus.in_ready   = sh_en;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.z_out      = z_q;
  assign bus.tail_valid = vld[STAGES];
  assign bus.tail_flip  = flip[STAGES];
  assign bus.busy       = |vld;

endmodule

// File: tb/tb_cordic_prep.sv
module tb_cordic_prep;

  localparam int unsigned STAGES = 16;

  logic clk;
  logic rst;

  cordic_prep_if bus ();

  cordic_prep #(
    .STAGES      (STAGES),
    .ANG_PI      (16'sd25736),
    .ANG_HALF_PI (16'sd12868),
    .K_INIT      (16'sd9949)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference fold computed with plain integer arithmetic.
  function automatic void ref_fold(input int a, output int z, output bit f);
    int t;
    t = a;
    if (t > 25736)  t = 25736;
    if (t < -25736) t = -25736;
    if (t > 12868) begin
      z = t - 25736; f = 1'b1;
    end else if (t < -12868) begin
      z = t + 25736; f = 1'b1;
    end else begin
      z = t; f = 1'b0;
    end
  endfunction

  // Model: one entry per sh_en edge, newest at the back; the tail is the
  // entry STAGES edges old.
  typedef struct {
    bit v;
    bit f;
    int z;
  } ent_t;
  ent_t q[$];
  bit   started = 1'b0;

  always @(posedge clk) begin
    ent_t e;
    int   z;
    bit   f;
    if (rst) begin
      q.delete();
      started <= 1'b1;
    end else if (bus.out_ready) begin
      ref_fold(int'(bus.angle_in), z, f);
      e.v = bus.in_valid;
      e.f = bus.in_valid & f;
      e.z = bus.in_valid ? z : 0;
      q.push_back(e);
      if (q.size() > STAGES + 1) void'(q.pop_front());
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    int ex, ez, etv, etf, eb, en;
    if (started) begin
      ex = 0; ez = 0; etv = 0; etf = 0; eb = 0;
      if (q.size() > 0 && q[$].v) begin
        ex = 9949;
        ez = q[$].z;
      end
      if (q.size() == STAGES + 1) begin
        etv = int'(q[0].v);
        etf = int'(q[0].f);
      end
      foreach (q[i]) if (q[i].v) eb = 1;
      en = int'(bus.out_ready & ~rst);
      check("x_out",      int'(bus.x_out),      ex);
      check("y_out",      int'(bus.y_out),      0);
      check("z_out",      int'(bus.z_out),      ez);
      check("tail_valid", int'(bus.tail_valid), etv);
      check("tail_flip",  int'(bus.tail_flip),  etf);
      check("busy",       int'(bus.busy),       eb);
      check("sh_en",      int'(bus.sh_en),      en);
      check("in_ready",   int'(bus.in_ready),   en);
    end
  end

  // Drive inputs for one cycle, then return #1 after the edge.
  task automatic cyc(input bit r, input bit v, input int a, input bit o);
    rst           = r;
    bus.in_valid  = v;
    bus.angle_in  = 16'(a);
    bus.out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int z;
    bit f;
    int k;
    int hold_z, hold_tv;
    int angles[5];

    rst = 1'b1; bus.in_valid = 1'b0; bus.angle_in = '0; bus.out_ready = 1'b1;

    // Pin the reference fold to hand-computed values.
    angles = '{20000, -20000, 12868, 30000, -32768};
    ref_fold(20000, z, f);  check("model_20000_z", z, -5736); check("model_20000_f", int'(f), 1);
    ref_fold(-20000, z, f); check("model_m20000_z", z, 5736); check("model_m20000_f", int'(f), 1);
    ref_fold(12868, z, f);  check("model_12868_z", z, 12868); check("model_12868_f", int'(f), 0);
    ref_fold(30000, z, f);  check("model_30000_z", z, 0);     check("model_30000_f", int'(f), 1);
    ref_fold(-32768, z, f); check("model_m32768_z", z, 0);    check("model_m32768_f", int'(f), 1);

    // Reset then idle.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("rst_x",     int'(bus.x_out), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_ready", int'(bus.in_ready), 1);

    // Angle 0 and its latency.
    cyc(0, 1, 0, 1);
    check("a0_x", int'(bus.x_out), 9949);
    check("a0_z", int'(bus.z_out), 0);
    k = 0;
    while (!bus.tail_valid && k < 100) begin
      cyc(0, 0, 0, 1);
      k++;
    end
    check("a0_latency", k, STAGES);
    check("a0_tail_flip", int'(bus.tail_flip), 0);

    // Directed fold corner cases.
    cyc(0, 1, 20000, 1);  check("d20000_z", int'(bus.z_out), -5736);
    cyc(0, 1, -20000, 1); check("dm20000_z", int'(bus.z_out), 5736);
    cyc(0, 1, 12868, 1);  check("d12868_z", int'(bus.z_out), 12868);
    cyc(0, 1, -12868, 1); check("dm12868_z", int'(bus.z_out), -12868);
    cyc(0, 1, 30000, 1);  check("d30000_z", int'(bus.z_out), 0);
    cyc(0, 1, -32768, 1); check("dm32768_z", int'(bus.z_out), 0);
    cyc(0, 1, 25736, 1);  check("dpi_z", int'(bus.z_out), 0);
    repeat (STAGES + 2) cyc(0, 0, 0, 1);

    // Stream 4 with a 3-cycle stall mid-stream.
    cyc(0, 1, 1000, 1);
    cyc(0, 1, 15000, 1);
    hold_z  = int'(bus.z_out);
    hold_tv = int'(bus.tail_valid);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 777, 0);
      check("stall_z",  int'(bus.z_out), hold_z);
      check("stall_tv", int'(bus.tail_valid), hold_tv);
    end
    cyc(0, 1, -15000, 1);
    cyc(0, 1, -1000, 1);
    repeat (STAGES + 2) cyc(0, 0, 0, 1);

    // Reset with three samples in flight.
    cyc(0, 1, 100, 1);
    cyc(0, 1, 20000, 1);
    cyc(0, 1, -20000, 1);
    cyc(1, 1, 5, 1);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_tv",   int'(bus.tail_valid), 0);
    cyc(0, 1, 20000, 1);
    k = 0;
    while (!bus.tail_valid && k < 100) begin
      cyc(0, 0, 0, 1);
      k++;
    end
    check("postrst_latency", k, STAGES);
    check("postrst_flip", int'(bus.tail_flip), 1);

    // Randomized traffic with boundary-biased angles, stalls and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5) a = int'($urandom_range(0, 65535)) - 32768;
      else a = angles[sel - 5] + int'($urandom_range(0, 2)) - 1;
      if (a > 32767) a = 32767;
      if (a < -32768) a = -32768;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, a,
          $urandom_range(0, 3) != 0);
    end
    repeat (STAGES + 2) cyc(0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
